// File: rtl/id_stage.sv
// id_stage: registered RV32I decode stage with operand forwarding, load-use interlock and
// sticky illegal-instruction capture. Define ID_MEMSIZE_EN to add memsize_o and width legality checks.
module id_stage #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [RAW-1:0]  gprs_raddr1,
  output logic [RAW-1:0]  gprs_raddr2,
  input  logic [XLEN-1:0] gprs_rdata1_i,
  input  logic [XLEN-1:0] gprs_rdata2_i,
  input  logic [RAW-1:0]  ex_gprs_waddr,
  input  logic [RAW-1:0]  mem_gprs_waddr,
  input  logic [XLEN-1:0] ex_gprs_wdata,
  input  logic [XLEN-1:0] mem_gprs_wdata,
  input  logic            ex_is_load,
  input  logic            flush_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      rtlop_o,
  output logic [1:0]      rtltype_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] src1_o,
  output logic [XLEN-1:0] src2_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [RAW-1:0]  gprs_waddr_o,
  output logic            error_o,
  output logic [XLEN-1:0] err_pc_o,
`ifdef ID_MEMSIZE_EN
  output logic [2:0]      memsize_o,
`endif
  output logic [31:0]     stall_cnt_o
);

  localparam logic [3:0] RTLOP_ADD = 4'd0;
  localparam logic [3:0] RTLOP_SHR = 4'd5;
  localparam logic [3:0] RTLOP_SAR = 4'd13;

  localparam logic [1:0] RTLTYPE_ARICH = 2'd0;
  localparam logic [1:0] RTLTYPE_RMEM  = 2'd1;
  localparam logic [1:0] RTLTYPE_WMEM  = 2'd2;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // EX result beats MEM result beats register file; x0 never forwards.
  function automatic logic signed [XLEN-1:0] fwd(
    input logic [RAW-1:0]  a,
    input logic [RAW-1:0]  ex_a,
    input logic [XLEN-1:0] ex_d,
    input logic [RAW-1:0]  mem_a,
    input logic [XLEN-1:0] mem_d,
    input logic [XLEN-1:0] gpr
  );
    if (a != '0 && a == ex_a)       return ex_d;
    else if (a != '0 && a == mem_a) return mem_d;
    else                            return gpr;
  endfunction

  logic [6:0]              opc_p0, f7_p0;
  logic [2:0]              f3_p0;
  logic [RAW-1:0]          rd_p0, rs1_p0, rs2_p0;
  logic signed [11:0]      imm_i12_p0, imm_s12_p0;
  logic signed [31:0]      imm_u32_p0;
  logic signed [XLEN-1:0]  imm_i_p0, imm_s_p0, imm_u_p0;
  logic signed [XLEN-1:0]  fwd1_p0, fwd2_p0;
  logic [3:0]              op_p0;
  logic [1:0]              type_p0;
  logic [XLEN-1:0]         src1_p0, src2_p0, sdata_p0;
  logic [RAW-1:0]          waddr_p0;
  logic                    ill_p0, use1_p0, use2_p0, stall_p0, accept_p0;
`ifdef ID_MEMSIZE_EN
  logic [2:0]              msize_p0, msize_p1;
`endif

  logic                    vld_p1, err_p1;
  logic [3:0]              op_p1;
  logic [1:0]              type_p1;
  logic [XLEN-1:0]         pc_p1, src1_p1, src2_p1, sdata_p1, err_pc_p1;
  logic [RAW-1:0]          waddr_p1;
  logic [31:0]             stall_cnt_p1;

  assign opc_p0     = instr_i[6:0];
  assign f3_p0      = instr_i[14:12];
  assign f7_p0      = instr_i[31:25];
  assign rd_p0      = RAW'(instr_i[11:7]);
  assign rs1_p0     = RAW'(instr_i[19:15]);
  assign rs2_p0     = RAW'(instr_i[24:20]);
  assign imm_i12_p0 = $signed(instr_i[31:20]);
  assign imm_s12_p0 = $signed({instr_i[31:25], instr_i[11:7]});
  assign imm_u32_p0 = $signed({instr_i[31:12], 12'h000});
  assign imm_i_p0   = XLEN'(imm_i12_p0);
  assign imm_s_p0   = XLEN'(imm_s12_p0);
  assign imm_u_p0   = XLEN'(imm_u32_p0);

  assign gprs_raddr1 = rs1_p0;
  assign gprs_raddr2 = rs2_p0;

  assign fwd1_p0 = fwd(rs1_p0, ex_gprs_waddr, ex_gprs_wdata, mem_gprs_waddr, mem_gprs_wdata, gprs_rdata1_i);
  assign fwd2_p0 = fwd(rs2_p0, ex_gprs_waddr, ex_gprs_wdata, mem_gprs_waddr, mem_gprs_wdata, gprs_rdata2_i);

  // Stage p0: combinational decode of the instruction presented by IF
  always_comb begin
    op_p0    = RTLOP_ADD;
    type_p0  = RTLTYPE_ARICH;
    src1_p0  = '0;
    src2_p0  = '0;
    sdata_p0 = '0;
    waddr_p0 = '0;
    ill_p0   = 1'b0;
    use1_p0  = 1'b0;
    use2_p0  = 1'b0;
`ifdef ID_MEMSIZE_EN
    msize_p0 = 3'd0;
`endif
    case (opc_p0)
      OPC_OP_IMM: begin
        use1_p0  = 1'b1;
        src1_p0  = fwd1_p0;
        src2_p0  = imm_i_p0;
        waddr_p0 = rd_p0;
        op_p0    = {1'b0, f3_p0};
        if (f3_p0 == 3'b001 && f7_p0 != F7_ZERO) begin
          ill_p0 = 1'b1;
        end else if (f3_p0 == 3'b101) begin
          if (f7_p0 == F7_ZERO)     op_p0  = RTLOP_SHR;
          else if (f7_p0 == F7_ALT) op_p0  = RTLOP_SAR;
          else                      ill_p0 = 1'b1;
        end
      end
      OPC_OP: begin
        use1_p0  = 1'b1;
        use2_p0  = 1'b1;
        src1_p0  = fwd1_p0;
        src2_p0  = fwd2_p0;
        waddr_p0 = rd_p0;
        op_p0    = {1'b0, f3_p0};
        case (f3_p0)
          3'b000: begin
            if (f7_p0 == F7_ALT) src2_p0 = -fwd2_p0;
            else if (f7_p0 != F7_ZERO) ill_p0 = 1'b1;
          end
          3'b101: begin
            if (f7_p0 == F7_ZERO)     op_p0  = RTLOP_SHR;
            else if (f7_p0 == F7_ALT) op_p0  = RTLOP_SAR;
            else                      ill_p0 = 1'b1;
          end
          default: if (f7_p0 != F7_ZERO) ill_p0 = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        use1_p0  = 1'b1;
        src1_p0  = fwd1_p0;
        src2_p0  = imm_i_p0;
        waddr_p0 = rd_p0;
        type_p0  = RTLTYPE_RMEM;
`ifdef ID_MEMSIZE_EN
        msize_p0 = f3_p0;
        if (f3_p0 == 3'd3 || f3_p0 == 3'd6 || f3_p0 == 3'd7) ill_p0 = 1'b1;
`endif
      end
      OPC_STORE: begin
        use1_p0  = 1'b1;
        use2_p0  = 1'b1;
        src1_p0  = fwd1_p0;
        src2_p0  = imm_s_p0;
        sdata_p0 = fwd2_p0;
        type_p0  = RTLTYPE_WMEM;
`ifdef ID_MEMSIZE_EN
        msize_p0 = f3_p0;
        if (f3_p0 > 3'd2) ill_p0 = 1'b1;
`endif
      end
      OPC_LUI: begin
        src1_p0  = imm_u_p0;
        waddr_p0 = rd_p0;
      end
      OPC_AUIPC: begin
        src1_p0  = pc_i;
        src2_p0  = imm_u_p0;
        waddr_p0 = rd_p0;
      end
      default: ill_p0 = 1'b1;
    endcase
    // Illegal instructions still flow to EX, but as a harmless NOP.
    if (ill_p0) begin
      op_p0    = RTLOP_ADD;
      type_p0  = RTLTYPE_ARICH;
      src1_p0  = '0;
      src2_p0  = '0;
      sdata_p0 = '0;
      waddr_p0 = '0;
`ifdef ID_MEMSIZE_EN
      msize_p0 = 3'd0;
`endif
    end
  end

  assign stall_p0  = in_valid & ex_is_load & (ex_gprs_waddr != '0) &
                     ((use1_p0 & (rs1_p0 == ex_gprs_waddr)) | (use2_p0 & (rs2_p0 == ex_gprs_waddr)));
  assign in_ready  = ~rst & ~stall_p0 & ~flush_i & (~vld_p1 | out_ready);
  assign accept_p0 = in_valid & in_ready;

  // Stage p1: registered micro-op presented to EX
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      op_p1        <= RTLOP_ADD;
      type_p1      <= RTLTYPE_ARICH;
      pc_p1        <= '0;
      src1_p1      <= '0;
      src2_p1      <= '0;
      sdata_p1     <= '0;
      waddr_p1     <= '0;
      err_p1       <= 1'b0;
      err_pc_p1    <= '0;
      stall_cnt_p1 <= 32'd0;
`ifdef ID_MEMSIZE_EN
      msize_p1     <= 3'd0;
`endif
    end else begin
      if (stall_p0) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      if (flush_i) begin
        vld_p1 <= 1'b0;
      end else if (accept_p0) begin
        vld_p1   <= 1'b1;
        op_p1    <= op_p0;
        type_p1  <= type_p0;
        pc_p1    <= pc_i;
        src1_p1  <= src1_p0;
        src2_p1  <= src2_p0;
        sdata_p1 <= sdata_p0;
        waddr_p1 <= waddr_p0;
`ifdef ID_MEMSIZE_EN
        msize_p1 <= msize_p0;
`endif
        if (ill_p0) begin
          err_p1 <= 1'b1;
          if (!err_p1) err_pc_p1 <= pc_i;
        end
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid    = vld_p1;
  assign rtlop_o      = op_p1;
  assign rtltype_o    = type_p1;
  assign pc_o         = pc_p1;
  assign src1_o       = src1_p1;
  assign src2_o       = src2_p1;
  assign store_data_o = sdata_p1;
  assign gprs_waddr_o = waddr_p1;
  assign error_o      = err_p1;
  assign err_pc_o     = err_pc_p1;
  assign stall_cnt_o  = stall_cnt_p1;
`ifdef ID_MEMSIZE_EN
  assign memsize_o    = msize_p1;
`endif

endmodule
